// File: rtl/instr_fetch_unit.sv
//------------------------------------------------------------------------------
// instr_fetch_unit
//
// Instruction supplier for a MIPS-style core. It owns the program counter. It
// fetches one word at a time from an instruction memory whose latency can
// vary. It presents that word to the control path as Instr/InstrValid. When
// the core retires the word, it uses the control path's PCSrc/jump decision
// to compute the next PC.
//
// Parameters
//   RESET_PC     PC loaded on reset. Bits [1:0] are always forced to zero.
//
// Ports
//   CLK          in   1   clock; all state changes on its rising edge
//   RST          in   1   asynchronous reset, active-low
//   PCSrc        in   1   branch taken; only looked at in a retire cycle
//   jump         in   1   jump instruction; only looked at in a retire cycle
//   Retire       in   1   core has executed Instr; advance the PC
//   imem_req     out  1   fetch request; held high until imem_rvalid
//   imem_addr    out  32  fetch address; always equals PC
//   imem_rvalid  in   1   imem_rdata is valid this cycle
//   imem_rdata   in   32  fetched instruction word
//   Instr        out  32  registered instruction; stable while InstrValid=1
//   InstrValid   out  1   Instr may be executed
//   PC           out  32  address of the current instruction
//   PCPlus4      out  32  PC + 4, combinational, wraps modulo 2^32
//   InstrCount   out  32  number of retired instructions; wraps at 2^32
//------------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        PCSrc,
    input  logic        jump,
    input  logic        Retire,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instr,
    output logic        InstrValid,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic [31:0] InstrCount
);

    // The PC is always word aligned, including straight out of reset.
    localparam logic [31:0] PC_INIT = {RESET_PC[31:2], 2'b00};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic        r_instr_valid;
    logic        r_imem_req;
    logic [31:0] r_instr_count;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_branch_off;
    logic [31:0] w_jump_target;
    logic [31:0] w_next_pc;

    //--------------------------------------------------------------------------
    // Next-PC datapath. It is only consumed in a HOLD cycle with Retire=1.
    // At that point Instr holds the word being retired.
    //--------------------------------------------------------------------------
    assign w_pc_plus4    = r_pc + 32'd4;
    assign w_branch_off  = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
    assign w_jump_target = {w_pc_plus4[31:28], r_instr[25:0], 2'b00};

    // NOTE: every signal written in always_comb gets a default first. A path
    // that leaves a signal unassigned would otherwise infer a latch.
    always_comb begin
        w_next_pc = w_pc_plus4;
        if (jump) begin
            w_next_pc = w_jump_target;           // a jump beats a taken branch
        end else if (PCSrc) begin
            w_next_pc = w_pc_plus4 + w_branch_off;  // 32-bit add, wraps
        end
    end

    //--------------------------------------------------------------------------
    // Fetch FSM. All outputs are registered, so each one is updated together
    // with the state transition that implies it:
    //   IDLE  -> FETCH : raise imem_req
    //   FETCH -> HOLD  : capture rdata, drop imem_req, raise InstrValid
    //   HOLD  -> FETCH : advance PC/count, drop InstrValid, raise imem_req
    // In IDLE the state does not look at imem_rvalid. A response that arrives
    // late for a fetch killed by reset therefore cannot land in Instr.
    //--------------------------------------------------------------------------
    // NOTE: state registers use non-blocking (<=) assignments. Every register
    // then samples pre-edge values, and no ordering race can occur between
    // always blocks.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state       <= S_IDLE;
            r_pc          <= PC_INIT;
            r_instr       <= 32'h0;
            r_instr_valid <= 1'b0;
            r_imem_req    <= 1'b0;
            r_instr_count <= 32'h0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_state    <= S_FETCH;
                    r_imem_req <= 1'b1;
                end

                S_FETCH: begin
                    // Without rvalid, the request and the address (PC) both
                    // stay put. Retire, PCSrc and jump have no effect here.
                    if (imem_rvalid) begin
                        r_instr       <= imem_rdata;
                        r_instr_valid <= 1'b1;
                        r_imem_req    <= 1'b0;
                        r_state       <= S_HOLD;
                    end
                end

                S_HOLD: begin
                    if (Retire) begin
                        r_pc          <= {w_next_pc[31:2], 2'b00};
                        r_instr_count <= r_instr_count + 32'd1;
                        r_instr_valid <= 1'b0;
                        r_imem_req    <= 1'b1;
                        r_state       <= S_FETCH;
                    end
                end

                default: begin
                    // Unreachable encoding: recover to a clean idle state.
                    r_state       <= S_IDLE;
                    r_instr_valid <= 1'b0;
                    r_imem_req    <= 1'b0;
                end
            endcase
        end
    end

    //--------------------------------------------------------------------------
    // Outputs
    //--------------------------------------------------------------------------
    assign imem_req   = r_imem_req;
    assign imem_addr  = r_pc;
    assign PC         = r_pc;
    assign PCPlus4    = w_pc_plus4;
    assign Instr      = r_instr;
    assign InstrValid = r_instr_valid;
    assign InstrCount = r_instr_count;

endmodule

// File: tb/tb_instr_fetch_unit.sv
//------------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Directed bench for instr_fetch_unit. A table of instruction transactions
// is applied by one task. Each entry gives the fetch address, memory data,
// rvalid delay, branch/jump decision, and the PC and count expected after
// retire. Hand-written sequences cover the reset corner cases.
//------------------------------------------------------------------------------
module tb_instr_fetch_unit;

    logic        CLK;
    logic        RST;
    logic        PCSrc;
    logic        jump;
    logic        Retire;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] Instr;
    logic        InstrValid;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic [31:0] InstrCount;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .PCSrc       (PCSrc),
        .jump        (jump),
        .Retire      (Retire),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .Instr       (Instr),
        .InstrValid  (InstrValid),
        .PC          (PC),
        .PCPlus4     (PCPlus4),
        .InstrCount  (InstrCount)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One instruction: fetch at addr, rvalid after 'delay' idle FETCH cycles,
    // then retire with the given branch/jump inputs.
    typedef struct {
        logic [31:0] addr;
        logic [31:0] rdata;
        int          delay;
        logic        pcsrc;
        logic        jmp;
        logic [31:0] next_addr;
        logic [31:0] count;
    } vec_t;

    vec_t vecs[12];

    // Entry condition: #1 after a rising edge with the DUT in FETCH.
    task automatic run_vec(input int idx, input vec_t v);
        string tag;
        tag = $sformatf("v%0d", idx);
        check({tag, " fetch imem_req"}, {31'b0, imem_req}, 32'd1);
        check({tag, " fetch imem_addr"}, imem_addr, v.addr);
        check({tag, " fetch InstrValid"}, {31'b0, InstrValid}, 32'd0);
        // Retire/PCSrc/jump are all raised during the wait cycles.
        // All three must be ignored while in FETCH.
        for (int d = 0; d < v.delay; d++) begin
            Retire = 1'b1; PCSrc = 1'b1; jump = 1'b1; imem_rvalid = 1'b0;
            @(posedge CLK); #1;
            Retire = 1'b0; PCSrc = 1'b0; jump = 1'b0;
            check({tag, " wait imem_req"}, {31'b0, imem_req}, 32'd1);
            check({tag, " wait imem_addr"}, imem_addr, v.addr);
            check({tag, " wait InstrValid"}, {31'b0, InstrValid}, 32'd0);
            check({tag, " wait InstrCount"}, InstrCount, v.count - 32'd1);
        end
        imem_rvalid = 1'b1; imem_rdata = v.rdata;
        @(posedge CLK); #1;
        imem_rvalid = 1'b0; imem_rdata = 32'hA5A5_A5A5;
        check({tag, " hold InstrValid"}, {31'b0, InstrValid}, 32'd1);
        check({tag, " hold Instr"}, Instr, v.rdata);
        check({tag, " hold imem_req"}, {31'b0, imem_req}, 32'd0);
        check({tag, " hold PCPlus4"}, PCPlus4, v.addr + 32'd4);
        Retire = 1'b1; PCSrc = v.pcsrc; jump = v.jmp;
        @(posedge CLK); #1;
        Retire = 1'b0; PCSrc = 1'b0; jump = 1'b0;
        check({tag, " retire InstrValid"}, {31'b0, InstrValid}, 32'd0);
        check({tag, " retire imem_req"}, {31'b0, imem_req}, 32'd1);
        check({tag, " retire PC"}, PC, v.next_addr);
        check({tag, " retire InstrCount"}, InstrCount, v.count);
    endtask

    initial begin
        //            addr          rdata        dly ps j  next          cnt
        vecs[0]  = '{32'h0000_0000, 32'h2000_0001, 0, 0, 0, 32'h0000_0004, 32'd1};
        vecs[1]  = '{32'h0000_0004, 32'h0000_0020, 0, 0, 0, 32'h0000_0008, 32'd2};
        vecs[2]  = '{32'h0000_0008, 32'h1000_0003, 0, 1, 0, 32'h0000_0018, 32'd3};
        vecs[3]  = '{32'h0000_0018, 32'h1000_FFFB, 0, 1, 0, 32'h0000_0008, 32'd4};
        vecs[4]  = '{32'h0000_0008, 32'h1000_FFFF, 3, 1, 0, 32'h0000_0008, 32'd5};
        vecs[5]  = '{32'h0000_0008, 32'h1000_FFFF, 0, 0, 0, 32'h0000_000C, 32'd6};
        vecs[6]  = '{32'h0000_000C, 32'h0BFF_FFFC, 0, 0, 1, 32'h0FFF_FFF0, 32'd7};
        vecs[7]  = '{32'h0FFF_FFF0, 32'h1000_0003, 0, 1, 0, 32'h1000_0000, 32'd8};
        vecs[8]  = '{32'h1000_0000, 32'h0800_0040, 0, 1, 1, 32'h1000_0100, 32'd9};
        vecs[9]  = '{32'h1000_0100, 32'h2000_0000, 1, 0, 0, 32'h1000_0104, 32'd10};
        // After a reset: branch backwards from 0 to the top word, then wrap.
        vecs[10] = '{32'h0000_0000, 32'h1000_FFFE, 0, 1, 0, 32'hFFFF_FFFC, 32'd1};
        vecs[11] = '{32'hFFFF_FFFC, 32'h0000_0000, 0, 0, 0, 32'h0000_0000, 32'd2};

        RST = 1'b0; PCSrc = 1'b0; jump = 1'b0; Retire = 1'b0;
        imem_rvalid = 1'b0; imem_rdata = 32'h0;

        // Check the reset state.
        repeat (2) @(posedge CLK);
        #1;
        check("rst imem_req", {31'b0, imem_req}, 32'd0);
        check("rst InstrValid", {31'b0, InstrValid}, 32'd0);
        check("rst PC", PC, 32'h0);
        check("rst Instr", Instr, 32'h0);
        check("rst InstrCount", InstrCount, 32'h0);
        check("rst PCPlus4", PCPlus4, 32'h4);
        RST = 1'b1;
        #1;
        check("idle imem_req", {31'b0, imem_req}, 32'd0);
        @(posedge CLK); #1;

        for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

        // Reset while in HOLD: the drop must be immediate, then IDLE holds
        // for exactly one cycle.
        imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678;
        @(posedge CLK); #1;
        imem_rvalid = 1'b0;
        check("pre-rst InstrValid", {31'b0, InstrValid}, 32'd1);
        RST = 1'b0;
        #1;
        check("hold-rst InstrValid", {31'b0, InstrValid}, 32'd0);
        check("hold-rst imem_req", {31'b0, imem_req}, 32'd0);
        check("hold-rst PC", PC, 32'h0);
        check("hold-rst InstrCount", InstrCount, 32'h0);
        @(posedge CLK); #1;
        RST = 1'b1;
        @(negedge CLK);
        check("post-rst idle imem_req", {31'b0, imem_req}, 32'd0);
        @(posedge CLK); #1;
        check("post-rst imem_req", {31'b0, imem_req}, 32'd1);
        check("post-rst imem_addr", imem_addr, 32'h0);

        for (int i = 10; i < 12; i++) run_vec(i, vecs[i]);

        // Reset during FETCH. A stale rvalid arrives in IDLE and must be
        // ignored.
        @(posedge CLK); #1;
        RST = 1'b0;
        #1;
        check("fetch-rst imem_req", {31'b0, imem_req}, 32'd0);
        check("fetch-rst InstrCount", InstrCount, 32'h0);
        RST = 1'b1;
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        @(posedge CLK); #1;
        imem_rvalid = 1'b0;
        check("stale imem_req", {31'b0, imem_req}, 32'd1);
        check("stale InstrValid", {31'b0, InstrValid}, 32'd0);
        check("stale Instr", Instr, 32'h0);
        @(posedge CLK); #1;
        check("stale later InstrValid", {31'b0, InstrValid}, 32'd0);
        check("stale later Instr", Instr, 32'h0);
        check("stale later imem_addr", imem_addr, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
